command_fifo: RTL and testbench

- Parametrised command queue between the FETCH/WRITE producer and the DECODE consumer; successor to the fixed 16-entry command store.
- Circular buffer, DEPTH entries of DATA_W bits, one push per cycle, up to two pops per cycle for dual-issue DECODE.
- First-word-fall-through read view, valid/ready push handshake, synchronous flush for branch redirect, occupancy count, almost-full flag and sticky pop-underflow error.

---
 rtl/cmd_pkg.sv | 18 +
 rtl/command_fifo_mem.sv | 29 ++
 rtl/command_fifo.sv | 97 +++++++++
 tb/tb_command_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command-queue definitions: command field layout and DECODE pop-count encodings.
package cmd_pkg;

    localparam int CMD_DATA_W = 14;
    localparam int CMD_ADDR_W = 12;
    localparam int CMD_OP_W   = 4;
    localparam int CMD_W      = CMD_DATA_W + CMD_ADDR_W + CMD_OP_W;

    // Command word is {data, addr, opcode}, opcode in the low bits.
    localparam int CMD_OP_LSB   = 0;
    localparam int CMD_ADDR_LSB = CMD_OP_LSB + CMD_OP_W;
    localparam int CMD_DATA_LSB = CMD_ADDR_LSB + CMD_ADDR_W;

    localparam logic [1:0] POP_NONE = 2'd0;
    localparam logic [1:0] POP_ONE  = 2'd1;
    localparam logic [1:0] POP_TWO  = 2'd2;

endpackage

// File: rtl/command_fifo_mem.sv
// Command storage: DEPTH x DATA_W register array, one write port, two async read ports.
module command_fifo_mem #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the queue count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/command_fifo.sv
// Command queue between FETCH/WRITE and dual-issue DECODE: FWFT read view, up to two pops per cycle.
module command_fifo
    import cmd_pkg::*;
#(
    parameter int DATA_W    = CMD_W,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic [1:0]                 rd_pop,
    output logic                       rd_valid0,
    output logic [DATA_W-1:0]          rd_data0,
    output logic                       rd_valid1,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       pop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr1;
    logic [CW-1:0]     count_q;
    logic              push;
    logic [1:0]        req_pop;
    logic [1:0]        avail;
    logic [1:0]        eff_pop;
    logic              pop_bad;
    logic [DATA_W-1:0] mem_rd0;
    logic [DATA_W-1:0] mem_rd1;

    // wr_ready comes from registered count only, so a same-cycle pop never admits a push when full.
    assign wr_ready    = (count_q != CW'(DEPTH));
    assign push        = wr_valid && wr_ready;
    assign almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign count       = count_q;
    assign rd_ptr1     = rd_ptr + PW'(1);

    always_comb begin
        req_pop = (rd_pop == 2'd3) ? POP_TWO : rd_pop;
        avail   = (count_q >= CW'(2)) ? POP_TWO : count_q[1:0];
        eff_pop = (req_pop < avail) ? req_pop : avail;
        pop_bad = (CW'(rd_pop) > count_q) || (rd_pop == 2'd3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pop_err <= 1'b0;
        end else begin
            if (pop_bad) begin
                pop_err <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                rd_ptr  <= rd_ptr + PW'(eff_pop);
                count_q <= count_q + CW'(push) - CW'(eff_pop);
            end
        end
    end

    command_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push && !flush),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .raddr0 (rd_ptr),
        .rdata0 (mem_rd0),
        .raddr1 (rd_ptr1),
        .rdata1 (mem_rd1)
    );

    assign rd_valid0 = (count_q >= CW'(1));
    assign rd_valid1 = (count_q >= CW'(2));
    assign rd_data0  = rd_valid0 ? mem_rd0 : '0;
    assign rd_data1  = rd_valid1 ? mem_rd1 : '0;

endmodule

// File: tb/tb_command_fifo.sv
// Directed self-checking bench for command_fifo (DEPTH 16, AF_MARGIN 2).
module tb_command_fifo;

    localparam int DATA_W = 30;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [1:0]        rd_pop = 2'd0;
    logic              rd_valid0;
    logic [DATA_W-1:0] rd_data0;
    logic              rd_valid1;
    logic [DATA_W-1:0] rd_data1;
    logic [4:0]        count;
    logic              almost_full;
    logic              pop_err;

    int checks = 0;
    int failures = 0;

    command_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_pop      (rd_pop),
        .rd_valid0   (rd_valid0),
        .rd_data0    (rd_data0),
        .rd_valid1   (rd_valid1),
        .rd_data1    (rd_data1),
        .count       (count),
        .almost_full (almost_full),
        .pop_err     (pop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd,
                         input logic [1:0] pop, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_pop   = pop;
        flush    = fl;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] q[$];
        logic [1:0]        p;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_valid0", 32'(rd_valid0), 0);
        chk("rst_valid1", 32'(rd_valid1), 0);
        chk("rst_data0", 32'(rd_data0), 0);
        chk("rst_data1", 32'(rd_data1), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_pop_err", 32'(pop_err), 0);
        reset = 1'b1;

        // Push 1..3, first entry visible the cycle after acceptance
        cycle(1'b1, 30'd1, 2'd0, 1'b0);
        chk("lat_valid0", 32'(rd_valid0), 1);
        chk("lat_data0", 32'(rd_data0), 1);
        chk("lat_valid1", 32'(rd_valid1), 0);
        cycle(1'b1, 30'd2, 2'd0, 1'b0);
        cycle(1'b1, 30'd3, 2'd0, 1'b0);
        chk("p3_count", 32'(count), 3);
        chk("p3_data0", 32'(rd_data0), 1);
        chk("p3_data1", 32'(rd_data1), 2);
        chk("p3_valid0", 32'(rd_valid0), 1);
        chk("p3_valid1", 32'(rd_valid1), 1);
        chk("p3_wr_ready", 32'(wr_ready), 1);

        // Fill to DEPTH, watching almost_full threshold at 14
        for (int i = 4; i <= 13; i++) cycle(1'b1, 30'(i), 2'd0, 1'b0);
        chk("c13_count", 32'(count), 13);
        chk("c13_af", 32'(almost_full), 0);
        cycle(1'b1, 30'd14, 2'd0, 1'b0);
        chk("c14_af", 32'(almost_full), 1);
        cycle(1'b1, 30'd15, 2'd0, 1'b0);
        cycle(1'b1, 30'd16, 2'd0, 1'b0);
        chk("full_count", 32'(count), 16);
        chk("full_wr_ready", 32'(wr_ready), 0);
        cycle(1'b1, 30'hAAAA, 2'd0, 1'b0);
        chk("stall_count", 32'(count), 16);
        chk("stall_wr_ready", 32'(wr_ready), 0);
        chk("stall_af", 32'(almost_full), 1);
        cycle(1'b1, 30'hAAAA, 2'd1, 1'b0);
        chk("full_pp_count", 32'(count), 15);
        chk("full_pp_data0", 32'(rd_data0), 2);
        chk("full_pp_wr_ready", 32'(wr_ready), 1);
        chk("full_pp_pop_err", 32'(pop_err), 0);
        // Pop to the tail: last entry must be 16, not the stalled 0xAAAA
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 2'd2, 1'b0);
        chk("tail_count", 32'(count), 1);
        chk("tail_data0", 32'(rd_data0), 16);

        // Interleave push with pop-2 across pointer wraps
        cycle(1'b0, '0, 2'd0, 1'b1);
        chk("flush1_count", 32'(count), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 30'(32'h100 + i), 2'd0, 1'b0);
            q.push_back(30'(32'h100 + i));
        end
        for (int i = 0; i < 40; i++) begin
            p = (i % 2 == 0) ? 2'd2 : 2'd0;
            cycle(1'b1, 30'(32'h200 + i), p, 1'b0);
            for (int k = 0; k < int'(p); k++) void'(q.pop_front());
            q.push_back(30'(32'h200 + i));
            chk("il_count", 32'(count), 32'(q.size()));
            chk("il_data0", 32'(rd_data0), 32'(q[0]));
            chk("il_data1", 32'(rd_data1), 32'(q[1]));
        end
        chk("il_pop_err", 32'(pop_err), 0);

        // Over-pop: count 1, request 2
        cycle(1'b0, '0, 2'd0, 1'b1);
        cycle(1'b1, 30'h55, 2'd0, 1'b0);
        chk("op_count1", 32'(count), 1);
        cycle(1'b0, '0, 2'd2, 1'b0);
        chk("op_count", 32'(count), 0);
        chk("op_valid0", 32'(rd_valid0), 0);
        chk("op_pop_err", 32'(pop_err), 1);
        cycle(1'b0, '0, 2'd0, 1'b0);
        chk("op_sticky", 32'(pop_err), 1);
        reset = 1'b0;
        #1;
        chk("op_rst_clear", 32'(pop_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // Flush overrides simultaneous push and pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 30'(32'h10 + i), 2'd0, 1'b0);
        chk("fl_count5", 32'(count), 5);
        cycle(1'b1, 30'h3FF, 2'd1, 1'b1);
        chk("fl_count", 32'(count), 0);
        chk("fl_valid0", 32'(rd_valid0), 0);
        chk("fl_data0", 32'(rd_data0), 0);
        cycle(1'b1, 30'h77, 2'd0, 1'b0);
        chk("fl_after_count", 32'(count), 1);
        chk("fl_after_data0", 32'(rd_data0), 32'h77);
        chk("fl_after_valid1", 32'(rd_valid1), 0);

        // Asynchronous reset between edges at count 7
        cycle(1'b0, '0, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 30'(32'h30 + i), 2'd0, 1'b0);
        chk("ar_count7", 32'(count), 7);
        wr_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_valid0", 32'(rd_valid0), 0);
        chk("ar_wr_ready", 32'(wr_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 30'hBEEF, 2'd0, 1'b0);
        chk("ar_push_data0", 32'(rd_data0), 32'hBEEF);
        chk("ar_push_count", 32'(count), 1);
        cycle(1'b0, '0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
